// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: divider FSM states, saturation limits, latency.
package alu_pkg;

  localparam int WIDTH   = 8;
  localparam int DIV_LAT = WIDTH + 2;

  localparam logic [7:0] SAT_MAX = 8'h7F;
  localparam logic [7:0] SAT_MIN = 8'h80;
  localparam logic [7:0] UMAX    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Unsigned (WIDTH+1)-bit trial subtract for the restoring divider; wraps, never saturates.
module div_trial_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_seq_8bit.sv
// Sequential restoring divider: LOAD takes magnitudes, ITER runs WIDTH shift/subtract
// steps, FIX restores signs and resolves divide-by-zero and signed overflow.
module div_seq_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   trial_a, trial_b, trial_diff;
  logic             trial_borrow, commit;
  logic [WIDTH-1:0] q_fix, r_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign trial_a = {rem_q, sh_q[WIDTH-1]};
  assign trial_b = {1'b0, dvs_mag_q};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // The partial remainder stays below the divisor, so a committed difference always fits.
  assign commit = ~trial_borrow & ~trial_diff[WIDTH];
  assign q_fix  = q_neg_q ? ({WIDTH{1'b0}} - sh_q)  : sh_q;
  assign r_fix  = r_neg_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dvs_mag_d = dvs_mag_q;
    rem_d     = rem_q;
    sh_d      = sh_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        // done_q marks the result cycle, which must not accept a new request
        if (start && !done_q) begin
          state_d = LOAD;
          dvd_d   = dividend;
          dvs_d   = divisor;
          sgn_d   = signed_op;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        dvs_mag_d = mag(dvs_q, sgn_q);
        sh_d      = mag(dvd_q, sgn_q);
        rem_d     = {WIDTH{1'b0}};
        q_neg_d   = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        r_neg_d   = sgn_q & dvd_q[WIDTH-1];
        cnt_d     = CW'(WIDTH - 1);
        state_d   = ITER;
      end
      ITER: begin
        if (commit) begin
          rem_d = trial_diff[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial_a[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == {CW{1'b0}}) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end
      FIX: begin
        if (dvs_q == {WIDTH{1'b0}}) begin
          dbz_d  = 1'b1;
          remo_d = dvd_q;
          if (sgn_q) begin
            quot_d = dvd_q[WIDTH-1] ? WIDTH'(SAT_MIN) : WIDTH'(SAT_MAX);
          end else begin
            quot_d = WIDTH'(UMAX);
          end
        end else if (sgn_q && (dvd_q == WIDTH'(SAT_MIN)) && (dvs_q == WIDTH'(UMAX))) begin
          ovf_d  = 1'b1;
          quot_d = WIDTH'(SAT_MAX);
          remo_d = {WIDTH{1'b0}};
        end else begin
          quot_d = q_fix;
          remo_d = r_fix;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ITER) || (state_d == FIX);
    done_d = (state_q == FIX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      sgn_q     <= 1'b0;
      dvd_q     <= {WIDTH{1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      dvs_mag_q <= {WIDTH{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      sh_q      <= {WIDTH{1'b0}};
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= {WIDTH{1'b0}};
      remo_q    <= {WIDTH{1'b0}};
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dvs_mag_q <= dvs_mag_d;
      rem_q     <= rem_d;
      sh_q      <= sh_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_div_seq_8bit.sv
// Directed self-checking bench for div_seq_8bit with hand-computed results.
module tb_div_seq_8bit;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       signed_op;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;

  div_seq_8bit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // pulses: extra start requests at 3 and 7 edges after accept; done_start: start in done cycle
  task automatic run_op(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input logic eovf, input logic pulses, input logic done_start);
    int lat;
    int bcnt;
    int extra;
    logic got;
    logic busy_at_done;
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; signed_op = ~s; dividend = 8'hA5; divisor = 8'h00;
    lat = 0; bcnt = 0; got = 1'b0; busy_at_done = 1'b0;
    while (!got && lat < 20) begin
      if (pulses && (lat == 3 || lat == 7)) begin
        start = 1'b1; dividend = 8'h11; divisor = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        got = 1'b1;
        busy_at_done = busy;
      end else if (busy) begin
        bcnt++;
      end
    end
    start = 1'b0;
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(DIV_LAT));
    check({tag, " busy cycles"}, 32'(bcnt), 32'd9);
    check({tag, " busy at done"}, 32'(busy_at_done), 32'd0);
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    check({tag, " ovf"}, 32'(ovf), 32'(eovf));
    if (done_start) begin
      start = 1'b1; signed_op = 1'b0; dividend = 8'h10; divisor = 8'h02;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " single done"}, 32'(done), 32'd0);
    check({tag, " quotient hold"}, 32'(quotient), 32'(eq));
    if (done_start) begin
      extra = 0;
      for (int i = 0; i < 14; i++) begin
        @(posedge clk);
        #1;
        if (done || busy) extra++;
      end
      check({tag, " start in done ignored"}, 32'(extra), 32'd0);
      check({tag, " remainder hold"}, 32'(remainder), 32'(er));
    end
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = 8'h00; divisor = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run_op("s 100/7",   1'b1, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("s -100/7",  1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("s 100/-7",  1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("u 200/3",   1'b0, 8'hC8, 8'h03, 8'h42, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("s -56/3",   1'b1, 8'hC8, 8'h03, 8'hEE, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("s 80/FF",   1'b1, 8'h80, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("s 45/0",    1'b1, 8'h2D, 8'h00, 8'h7F, 8'h2D, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("s -5/0",    1'b1, 8'hFB, 8'h00, 8'h80, 8'hFB, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("u 9/0",     1'b0, 8'h09, 8'h00, 8'hFF, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("u 128/255", 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("s -128/7",  1'b1, 8'h80, 8'h07, 8'hEE, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of an operation discards it
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; dividend = 8'h64; divisor = 8'h07;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst quotient", 32'(quotient), 32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    check("midrst dbz", 32'(div_by_zero), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("midrst no done", 32'(dones), 32'd0);

    run_op("post-rst s 100/7", 1'b1, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("u 255/1",          1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
